// File: rtl/deserializer_if.sv
// Interface for the deserializer: serial input controls plus the parallel
// output vector and its valid/ready handshake.
interface deserializer_if #(
  parameter int OUTPUT_SIZE = 4,
  parameter int Q_SIZE      = 16
) ();
  localparam int CW = $clog2(OUTPUT_SIZE + 1);

  logic                                deserializer_start;
  logic                                deserializer_shift;
  logic [Q_SIZE-1:0]                   serial_in;
  logic [OUTPUT_SIZE-1:0][Q_SIZE-1:0]  data_out;
  logic                                out_valid;
  logic                                out_ready;
  logic                                overrun;
  logic [CW-1:0]                       word_count;

  // Producer/consumer side driving the deserializer
  modport master (
    output deserializer_start, deserializer_shift, serial_in, out_ready,
    input  data_out, out_valid, overrun, word_count
  );

  // The deserializer itself
  modport slave (
    input  deserializer_start, deserializer_shift, serial_in, out_ready,
    output data_out, out_valid, overrun, word_count
  );
endinterface

// File: rtl/deserializer.sv
// Deserializer: gathers Q_SIZE-bit words (element 0 first) into an
// OUTPUT_SIZE-element vector, held on a registered output with a
// valid/ready handshake and a sticky overrun flag.
module deserializer #(
  parameter int OUTPUT_SIZE = 4,
  parameter int Q_SIZE      = 16
) (
  input logic           clk,
  input logic           rst,
  deserializer_if.slave bus
);
  localparam int CW = $clog2(OUTPUT_SIZE + 1);

  typedef logic [OUTPUT_SIZE-1:0][Q_SIZE-1:0] vec_t;

  vec_t          part_q, part_d;
  vec_t          data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] idx;
  logic          complete;
  logic          transfer;

  // Write index for this cycle and whether it finishes a vector
  always_comb begin
    idx      = bus.deserializer_start ? '0 : count_q;
    complete = bus.deserializer_shift && (idx == CW'(OUTPUT_SIZE - 1));
    transfer = valid_q && bus.out_ready;
  end

  // Partial buffer: only the addressed element takes the incoming word
  for (genvar gi = 0; gi < OUTPUT_SIZE; gi++) begin : g_part
    assign part_d[gi] = (bus.deserializer_shift && (idx == CW'(gi)))
                        ? bus.serial_in : part_q[gi];
  end

  // Next-state for word counter, output vector, valid and overrun
  always_comb begin
    count_d = count_q;
    if (bus.deserializer_shift) begin
      count_d = complete ? '0 : idx + CW'(1);
    end else if (bus.deserializer_start) begin
      // Start without a word abandons any partial vector silently
      count_d = '0;
    end

    // part_d already holds the final word, so the completed vector is whole
    data_d = complete ? part_d : data_q;

    valid_d = valid_q;
    if (complete) begin
      valid_d = 1'b1;
    end else if (transfer) begin
      valid_d = 1'b0;
    end

    // A completion only overruns if the held vector is not leaving now
    ovr_d = ovr_q | (complete & valid_q & ~bus.out_ready);
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      part_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      count_q <= '0;
    end else begin
      part_q  <= part_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      count_q <= count_d;
    end
  end

  assign bus.data_out   = data_q;
  assign bus.out_valid  = valid_q;
  assign bus.overrun    = ovr_q;
  assign bus.word_count = count_q;
endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive-side counterpart of the lane serializer: collects a stream of Q_SIZE-bit words, element 0 first, and assembles them into an OUTPUT_SIZE-element parallel vector.
- Sits between a serial activation/weight lane and a layer's parallel input.
- Presents each completed vector on a held output register with a valid/ready handshake and a sticky overrun flag.

Parameters:
- OUTPUT_SIZE, 4: number of elements per assembled vector (>=1).
- Q_SIZE, 16: width of one fixed-point element in bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- deserializer_start  in  1  marks the start of a new vector; with deserializer_shift, serial_in is element 0.
- deserializer_shift  in  1  serial_in carries a valid word this cycle.
- serial_in  in  Q_SIZE  incoming element.
- data_out  out  OUTPUT_SIZE x Q_SIZE  last completed vector; element i is the i-th word received.
- out_valid  out  1  data_out holds an unconsumed vector.
- out_ready  in  1  consumer accepts data_out this cycle.
- overrun  out  1  sticky: a completed vector overwrote an unconsumed one.
- word_count  out  $clog2(OUTPUT_SIZE+1)  words captured in the current partial vector.

Behaviour:
- Reset (rst=1 at an edge, overrides everything):
  - data_out=0, partial buffer=0, out_valid=0, overrun=0, word_count=0.
  - A vector in progress is discarded.
- Capture, on a cycle with deserializer_shift=1:
  - The index is 0 if deserializer_start=1, else word_count.
  - serial_in is written into the partial buffer at that index.
  - word_count becomes index+1, or 0 if index==OUTPUT_SIZE-1.
- Start without shift: deserializer_start=1 with deserializer_shift=0 sets word_count=0 and captures nothing. Any partial vector is abandoned, with no output and no flag.
- Start mid-vector: deserializer_start=1 with deserializer_shift=1 while word_count!=0 abandons the partial vector. The current word becomes element 0.
- Completion (shift cycle with index==OUTPUT_SIZE-1):
  - At that edge, data_out is loaded with the full vector, including the current serial_in in element OUTPUT_SIZE-1.
  - out_valid=1 from the next cycle.
  - Latency from the last word to out_valid is 1 cycle.
  - Elements not rewritten since start keep stale buffer contents. A start always rewrites index 0 onward, so a normal stream is fully defined.
- Handshake:
  - Transfer occurs on a cycle with out_valid=1 and out_ready=1; out_valid drops next cycle unless a completion occurs in the same cycle.
  - out_ready while out_valid=0 is ignored.
  - data_out is stable while out_valid=1 until a transfer or a new completion.
- Simultaneous completion and transfer: data_out takes the new vector, out_valid stays 1, no overrun.
- Completion with out_valid=1 and out_ready=0: data_out takes the new vector, out_valid stays 1, overrun=1. overrun is sticky until rst.
- OUTPUT_SIZE=1: every shift is a completion; word_count is always 0.
- Idle cycle (deserializer_shift=0, deserializer_start=0): partial buffer and word_count hold. No x-propagation; all state is always defined.
- No combinational path from serial_in or the controls to outputs; all outputs are registered.

Test Plan:
- Reset and basic vector:
  - Stimulus: OUTPUT_SIZE=4, Q_SIZE=16; after rst, drive shift with start on the first word; words 0x0011,0x0022,0x0033,0x0044 on 4 consecutive cycles; out_ready=1.
  - Required: out_valid=1 for exactly one cycle, 1 cycle after the last word; data_out={0x0011,0x0022,0x0033,0x0044} in index order; overrun=0.
- Gapped stream:
  - Stimulus: the same 4 words with 2 idle cycles between each.
  - Required: word_count steps 1,2,3,0; the identical vector appears; out_valid rises 1 cycle after the 4th word.
- Back-pressure and overrun:
  - Stimulus: out_ready=0; send two full vectors A then B.
  - Required: data_out=A after A; then data_out=B and overrun=1 after B; out_valid stays 1.
  - Then: raise out_ready for 1 cycle. Required: out_valid=0 next cycle; overrun remains 1.
- Restart mid-vector:
  - Stimulus: send 2 words, then start+shift with 0x00AA, then 3 more words 0x00BB,0x00CC,0x00DD.
  - Required: exactly one output, {0x00AA,0x00BB,0x00CC,0x00DD}.
- Completion with simultaneous transfer:
  - Stimulus: hold vector A valid, then complete B on a cycle where out_ready=1.
  - Required: data_out=B; out_valid stays 1; overrun=0.
- Reset mid-operation:
  - Stimulus: assert rst after 3 of 4 words, with out_valid=1 and overrun=1.
  - Required: next cycle all outputs are 0. A following 1-word completion without start does not complete a vector; word_count=1.
